// File: rtl/pll_supervisor_pkg.sv
// -----------------------------------------------------------------------------
// pll_supervisor_pkg
// Shared definitions for the PLL supervisor: the FSM state type, the default
// parameter constants and a helper that sizes the internal counters.
// -----------------------------------------------------------------------------
package pll_supervisor_pkg;

    // Supervisor FSM states
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUNNING   = 3'd3,
        FAULT     = 3'd4
    } pll_state_t;

    // Default parameter values
    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 500000;  // 10 ms at 50 MHz
    localparam int DEF_LOSS_CNT_W          = 8;

    // Counter width able to hold 0 .. n-1; a single bit is kept as the floor
    // so that n == 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage : pll_supervisor_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single-bit level signal crossing into clk.
// Both flops are cleared to RST_VAL by a synchronous active-high reset.
//
// Ports:
//   clk  in   destination clock
//   rst  in   synchronous reset, active-high
//   d    in   asynchronous input level
//   q    out  synchronized level (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Synchronizer flop chain; meta_r may go metastable, sync_r is the safe copy
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule : sync_2ff

// File: rtl/pll_supervisor.sv
// -----------------------------------------------------------------------------
// pll_supervisor
// Sequences a PLL out of reset, waits for a stable lock and then releases the
// downstream clock domain. Lock losses while running are counted and send the
// supervisor back to waiting for lock. A lock that never arrives raises a
// sticky timeout flag.
//
// Build option:
//   PLL_SUPERVISOR_AUTORETRY_EN  defined     : a lock timeout restarts the PLL
//                                              reset pulse, retrying forever
//                                undefined   : a lock timeout parks in FAULT
//                                              until rst
//
// Ports:
//   clk          in   50 MHz reference clock (also the PLL refclk)
//   rst          in   synchronous reset, active-high
//   pll_locked   in   PLL lock flag, asynchronous to clk
//   pll_rst      out  PLL reset, active-high
//   domain_rst   out  reset for PLL-clock logic, active-high
//   ready        out  high while locked and stable
//   loss_count   out  saturating count of lock losses seen while running
//   timeout_err  out  sticky lock-timeout flag
// -----------------------------------------------------------------------------
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOSS_CNT_W          = DEF_LOSS_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic                  domain_rst,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] loss_count,
    output logic                  timeout_err
);

    // Reject illegal configurations at elaboration
    if (RST_PULSE_CYCLES < 1) begin : g_bad_rst_pulse
        $error("pll_supervisor: RST_PULSE_CYCLES must be >= 1");
    end
    if (LOCK_STABLE_CYCLES < 1) begin : g_bad_lock_stable
        $error("pll_supervisor: LOCK_STABLE_CYCLES must be >= 1");
    end
    if (LOCK_TIMEOUT_CYCLES < 1) begin : g_bad_lock_timeout
        $error("pll_supervisor: LOCK_TIMEOUT_CYCLES must be >= 1");
    end
    if (LOSS_CNT_W < 1) begin : g_bad_loss_w
        $error("pll_supervisor: LOSS_CNT_W must be >= 1");
    end

    localparam int RST_CW = cnt_width(RST_PULSE_CYCLES);
    localparam int STB_CW = cnt_width(LOCK_STABLE_CYCLES);
    localparam int TMO_CW = cnt_width(LOCK_TIMEOUT_CYCLES);

    localparam logic [RST_CW-1:0] RST_LAST = RST_CW'(RST_PULSE_CYCLES - 1);
    localparam logic [STB_CW-1:0] STB_LAST = STB_CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_CW-1:0] TMO_LAST = TMO_CW'(LOCK_TIMEOUT_CYCLES - 1);

    logic                  lock_s;

    pll_state_t            state_r;
    pll_state_t            next_state_s;

    logic [RST_CW-1:0]     rst_cnt_r;
    logic [RST_CW-1:0]     rst_cnt_nxt_s;
    logic [TMO_CW-1:0]     tmo_cnt_r;
    logic [TMO_CW-1:0]     tmo_cnt_nxt_s;
    logic [STB_CW-1:0]     stb_cnt_r;
    logic [STB_CW-1:0]     stb_cnt_nxt_s;

    logic                  loss_inc_s;
    logic                  tmo_set_s;

    logic                  pll_rst_r;
    logic                  domain_rst_r;
    logic                  ready_r;
    logic [LOSS_CNT_W-1:0] loss_cnt_r;
    logic                  timeout_err_r;

    sync_2ff #(
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // Next-state and counter logic. Counters default to zero so that every
    // state is entered with a fresh count.
    always_comb begin
        next_state_s  = state_r;
        rst_cnt_nxt_s = '0;
        tmo_cnt_nxt_s = '0;
        stb_cnt_nxt_s = '0;
        loss_inc_s    = 1'b0;
        tmo_set_s     = 1'b0;

        case (state_r)
            RESET_PLL: begin
                if (rst_cnt_r == RST_LAST) begin
                    next_state_s = WAIT_LOCK;
                end else begin
                    rst_cnt_nxt_s = rst_cnt_r + RST_CW'(1);
                end
            end

            WAIT_LOCK: begin
                // The timeout terminal count wins over a lock in the same cycle
                if (tmo_cnt_r == TMO_LAST) begin
                    tmo_set_s = 1'b1;
`ifdef PLL_SUPERVISOR_AUTORETRY_EN
                    next_state_s = RESET_PLL;
`else
                    next_state_s = FAULT;
`endif
                end else if (lock_s) begin
                    // This cycle is already the first locked cycle, so the
                    // stable count starts at 1 and RUNNING is reached exactly
                    // LOCK_STABLE_CYCLES cycles after it.
                    if (LOCK_STABLE_CYCLES == 1) begin
                        next_state_s = RUNNING;
                    end else begin
                        next_state_s  = STABILIZE;
                        stb_cnt_nxt_s = STB_CW'(1);
                    end
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TMO_CW'(1);
                end
            end

            STABILIZE: begin
                // Losing lock wins over the stable terminal count
                if (!lock_s) begin
                    next_state_s = WAIT_LOCK;
                end else if (stb_cnt_r == STB_LAST) begin
                    next_state_s = RUNNING;
                end else begin
                    stb_cnt_nxt_s = stb_cnt_r + STB_CW'(1);
                end
            end

            RUNNING: begin
                if (!lock_s) begin
                    next_state_s = WAIT_LOCK;
                    loss_inc_s   = 1'b1;
                end else begin
                    next_state_s = RUNNING;
                end
            end

            FAULT: begin
                next_state_s = FAULT;
            end

            default: begin
                next_state_s = RESET_PLL;
            end
        endcase
    end

    // State, counters and outputs. Outputs are decoded from the next state so
    // they change on the same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= RESET_PLL;
            rst_cnt_r     <= '0;
            tmo_cnt_r     <= '0;
            stb_cnt_r     <= '0;
            pll_rst_r     <= 1'b1;
            domain_rst_r  <= 1'b1;
            ready_r       <= 1'b0;
            loss_cnt_r    <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            rst_cnt_r     <= rst_cnt_nxt_s;
            tmo_cnt_r     <= tmo_cnt_nxt_s;
            stb_cnt_r     <= stb_cnt_nxt_s;
            pll_rst_r     <= (next_state_s == RESET_PLL);
            domain_rst_r  <= (next_state_s != RUNNING);
            ready_r       <= (next_state_s == RUNNING);
            timeout_err_r <= timeout_err_r | tmo_set_s;
            if (loss_inc_s && (loss_cnt_r != '1)) begin
                loss_cnt_r <= loss_cnt_r + LOSS_CNT_W'(1);
            end else begin
                loss_cnt_r <= loss_cnt_r;
            end
        end
    end

    assign pll_rst     = pll_rst_r;
    assign domain_rst  = domain_rst_r;
    assign ready       = ready_r;
    assign loss_count  = loss_cnt_r;
    assign timeout_err = timeout_err_r;

endmodule : pll_supervisor

// File: doc/pll_supervisor.md
PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 Parameter RST_PULSE_CYCLES, default 16: number of cycles pll_rst is held high per PLL reset request.
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024: number of consecutive synchronized-locked cycles required before ready is asserted.
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 500000 (10 ms at 50 MHz): maximum wait for lock after pll_rst is released.
REQ-004 Parameter LOSS_CNT_W, default 8: width of the lock-loss counter.
REQ-005 clk  input  1  50 MHz reference clock, the same clock that drives the PLL refclk.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 pll_locked  input  1  PLL locked flag, asynchronous to clk.
REQ-008 pll_rst  output  1  reset to the PLL rst pin, active-high.
REQ-009 domain_rst  output  1  active-high reset for downstream PLL-clock logic; consumers resynchronize it into their own domain.
REQ-010 ready  output  1  high while the PLL is locked and stable.
REQ-011 loss_count  output  LOSS_CNT_W  saturating count of lock losses seen in RUNNING.
REQ-012 timeout_err  output  1  sticky flag, set when a lock timeout occurs.

Function
REQ-013 pll_locked shall pass through a 2-flop synchronizer; all logic uses only the synchronized value, lock_s.
REQ-014 FSM states: RESET_PLL, WAIT_LOCK, STABILIZE, RUNNING, FAULT.
REQ-015 RESET_PLL: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK.
REQ-016 WAIT_LOCK: pll_rst=0; a timeout counter starts at 0 on entry.
- lock_s=1 -> STABILIZE.
- Counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0 -> set timeout_err and apply REQ-027 handling.
REQ-017 STABILIZE: a stable counter increments each cycle lock_s=1.
- lock_s=0 -> counter clears and the state returns to WAIT_LOCK with a fresh timeout count.
- Counter reaches LOCK_STABLE_CYCLES-1 -> RUNNING.
REQ-018 RUNNING: ready=1 and domain_rst=0.
- lock_s=0 -> loss_count increments (saturating at all-ones), ready=0 and domain_rst=1 on the next cycle, and the state returns to WAIT_LOCK.
REQ-019 domain_rst shall be 1 in every state except RUNNING; ready shall be 1 only in RUNNING; both are registered outputs.
REQ-020 Latency: a lock_s fall in RUNNING deasserts ready within 1 cycle; end to end from pll_locked this is at most 3 cycles.
REQ-021 Entry into RUNNING shall occur exactly LOCK_STABLE_CYCLES cycles after the first lock_s=1 cycle of an uninterrupted lock.
REQ-022 Counter widths shall be $clog2 of the respective parameter; parameters below 1 are illegal and shall be rejected by an elaboration-time check.
REQ-023 Counter terminal conditions shall take priority over lock_s when both occur in the same cycle, except in STABILIZE, where lock_s=0 takes priority.
REQ-024 FAULT: pll_rst=0, domain_rst=1 and ready=0; the block stays in FAULT until rst is asserted.

Reset
REQ-025 While rst=1 and on the first cycle after release:
- state=RESET_PLL and all counters are 0.
- pll_rst=1, domain_rst=1, ready=0, loss_count=0, timeout_err=0.
- The synchronizer flops are 0.
REQ-026 Asserting rst mid-operation, in any state, shall return the block to the REQ-025 values on the next clk edge.

Configuration
REQ-027 Macro PLL_SUPERVISOR_AUTORETRY_EN controls timeout handling.
- Defined: a WAIT_LOCK timeout returns to RESET_PLL for a new reset pulse, retrying indefinitely; timeout_err is still set.
- Not defined: a WAIT_LOCK timeout enters FAULT.

Structure
REQ-028 A shared package pll_supervisor_pkg shall hold the state enum type and the default parameter constants.
REQ-029 The 2-flop synchronizer shall be one sub-module, sync_2ff, reusable elsewhere in the codebase.

Verification
REQ-030 The bench shall use RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8 and LOCK_TIMEOUT_CYCLES=100 for the following scenarios.
REQ-031 Normal lock:
- Stimulus: release rst, then raise pll_locked 10 cycles after pll_rst falls.
- Response: pll_rst is high for exactly 4 cycles; ready rises 2+8 cycles after the pll_locked edge.
REQ-032 Glitch during STABILIZE:
- Stimulus: drop pll_locked for 1 cycle at stable count 5.
- Response: the counter restarts; ready rises 8 cycles after relock; loss_count=0.
REQ-033 Loss in RUNNING:
- Stimulus: drop pll_locked for 20 cycles, then restore it.
- Response: ready=0 within 3 cycles; loss_count=1; ready returns after relock plus 8 cycles.
REQ-034 Timeout:
- Stimulus: keep pll_locked=0.
- Response with the macro defined: timeout_err=1 after 4+100 cycles, then a new 4-cycle pll_rst pulse.
- Response without the macro: the block stays in FAULT with pll_rst=0.
REQ-035 Saturation and mid-operation reset:
- Stimulus: force 300 losses, then assert rst while in RUNNING.
- Response: loss_count holds at 255 until rst; after rst, all outputs match REQ-025.
